// File: rtl/dtb_pkg.sv
// Shared trace-buffer types: control/status words, readout width and the host reader FSM states.
package dtb_pkg;

    localparam int TRB_WIDTH      = 32;
    localparam int STATUS_TRG_BIT = 0;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] arg;
    } control_t;

    typedef logic [7:0] status_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CTRL = 3'd1,
        WAIT_TRIG = 3'd2,
        READ      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic status_is_trig(input status_t s);
        return s[STATUS_TRG_BIT];
    endfunction

endpackage

// File: rtl/trace_host_reader_rv_output_reg.sv
// One-entry full-throughput ready/valid register slice; accepts a new word whenever empty or draining.
module rv_output_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             load_s;

    assign in_ready  = !valid_r || out_ready;
    assign load_s    = in_valid && in_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slot occupancy and payload; a reload in the same cycle as the pop keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_host_reader.sv
// Host-side reader: sends one control word, optionally waits for a trigger status, then streams
// a fixed number of trace-buffer words to the output with no bubbles.
module trace_host_reader
    import dtb_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         CMD_VALID_I,
    output logic                         CMD_READY_O,
    input  logic [$bits(control_t)-1:0]  CMD_CONTROL_I,
    input  logic [COUNT_W-1:0]           CMD_COUNT_I,
    input  logic                         CMD_WAIT_TRIG_I,
    output logic                         CONTROL_VALID_O,
    input  logic                         CONTROL_READY_I,
    output logic [$bits(control_t)-1:0]  CONTROL_O,
    input  logic                         STATUS_VALID_I,
    output logic                         STATUS_READY_O,
    input  logic [$bits(status_t)-1:0]   STATUS_I,
    input  logic                         DATA_VALID_I,
    output logic                         DATA_READY_O,
    input  logic [TRB_WIDTH-1:0]         DATA_I,
    output logic                         OUT_VALID_O,
    input  logic                         OUT_READY_I,
    output logic [TRB_WIDTH-1:0]         OUT_DATA_O,
    input  logic                         ABORT_I,
    output logic                         BUSY_O,
    output logic                         DONE_O,
    output logic [$bits(status_t)-1:0]   LAST_STATUS_O
);

    state_t               state_r;
    state_t               state_next_s;
    control_t             ctrl_r;
    logic [COUNT_W-1:0]   count_r;
    logic                 wait_r;
    status_t              last_status_r;

    logic                 abort_s;
    logic                 cmd_acc_s;
    logic                 ctrl_acc_s;
    logic                 status_acc_s;
    logic                 data_acc_s;
    logic                 read_en_s;
    logic                 reg_in_ready_s;
    logic                 reg_valid_s;
    logic [TRB_WIDTH-1:0] reg_data_s;
    logic                 count_zero_s;

    // All handshake outputs are gated by reset so they read zero even before the first reset edge.
    assign abort_s         = ABORT_I && (state_r != IDLE);
    assign read_en_s       = (state_r == READ) && !ABORT_I && !RST_I;
    assign CMD_READY_O     = (state_r == IDLE) && !RST_I;
    assign CONTROL_VALID_O = (state_r == SEND_CTRL) && !ABORT_I && !RST_I;
    assign STATUS_READY_O  = !RST_I;
    assign DATA_READY_O    = read_en_s && reg_in_ready_s;
    assign BUSY_O          = (state_r != IDLE) && !RST_I;
    assign DONE_O          = (state_r == DONE) && !RST_I;
    assign OUT_VALID_O     = reg_valid_s && !RST_I;
    assign OUT_DATA_O      = RST_I ? '0 : reg_data_s;
    assign CONTROL_O       = RST_I ? '0 : ctrl_r;
    assign LAST_STATUS_O   = RST_I ? '0 : last_status_r;

    assign cmd_acc_s    = CMD_VALID_I && CMD_READY_O;
    assign ctrl_acc_s   = CONTROL_VALID_O && CONTROL_READY_I;
    assign status_acc_s = STATUS_VALID_I && STATUS_READY_O;
    assign data_acc_s   = DATA_VALID_I && DATA_READY_O;
    assign count_zero_s = (count_r == '0);

    // FSM state register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Job context: latched command, remaining word count and the most recent status word.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ctrl_r        <= '0;
            count_r       <= '0;
            wait_r        <= 1'b0;
            last_status_r <= '0;
        end else begin
            if (status_acc_s) begin
                last_status_r <= status_t'(STATUS_I);
            end
            if (cmd_acc_s) begin
                ctrl_r  <= control_t'(CMD_CONTROL_I);
                count_r <= CMD_COUNT_I;
                wait_r  <= CMD_WAIT_TRIG_I;
            end else if (data_acc_s) begin
                count_r <= count_r - COUNT_W'(1);
            end
        end
    end

    // Next-state logic; abort overrides every other event in a busy state.
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_acc_s) state_next_s = SEND_CTRL;
                    else           state_next_s = IDLE;
                end
                SEND_CTRL: begin
                    if (!ctrl_acc_s)  state_next_s = SEND_CTRL;
                    else if (wait_r)  state_next_s = WAIT_TRIG;
                    else if (!count_zero_s) state_next_s = READ;
                    else              state_next_s = DONE;
                end
                WAIT_TRIG: begin
                    if (!(status_acc_s && status_is_trig(status_t'(STATUS_I)))) state_next_s = WAIT_TRIG;
                    else if (!count_zero_s) state_next_s = READ;
                    else                    state_next_s = DONE;
                end
                READ: begin
                    if (data_acc_s && (count_r == COUNT_W'(1))) state_next_s = DRAIN;
                    else                                         state_next_s = READ;
                end
                DRAIN: begin
                    if (!reg_valid_s) state_next_s = DONE;
                    else              state_next_s = DRAIN;
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    rv_output_reg #(
        .WIDTH(TRB_WIDTH)
    ) u_out_reg (
        .clk      (CLK_I),
        .rst      (RST_I),
        .flush    (abort_s),
        .in_valid (DATA_VALID_I && read_en_s),
        .in_ready (reg_in_ready_s),
        .in_data  (DATA_I),
        .out_valid(reg_valid_s),
        .out_ready(OUT_READY_I),
        .out_data (reg_data_s)
    );

endmodule

// File: tb/tb_trace_host_reader.sv
// Bench for trace_host_reader: per-cycle comparison against a job-level model plus directed scenarios.
module tb_trace_host_reader;
    import dtb_pkg::*;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        CMD_VALID_I = 1'b0;
    logic        CMD_READY_O;
    logic [15:0] CMD_CONTROL_I = 16'h0000;
    logic [15:0] CMD_COUNT_I = 16'h0000;
    logic        CMD_WAIT_TRIG_I = 1'b0;
    logic        CONTROL_VALID_O;
    logic        CONTROL_READY_I = 1'b1;
    logic [15:0] CONTROL_O;
    logic        STATUS_VALID_I = 1'b0;
    logic        STATUS_READY_O;
    logic [7:0]  STATUS_I = 8'h00;
    logic        DATA_VALID_I = 1'b1;
    logic        DATA_READY_O;
    logic [31:0] DATA_I;
    logic        OUT_VALID_O;
    logic        OUT_READY_I = 1'b1;
    logic [31:0] OUT_DATA_O;
    logic        ABORT_I = 1'b0;
    logic        BUSY_O;
    logic        DONE_O;
    logic [7:0]  LAST_STATUS_O;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit rnd = 1'b0;
    int unsigned acc_total = 0;
    int out_q[$];
    int done_q[$];
    int ctrl_q[$];
    int dacc_q[$];

    // Each source word is a distinct function of how many words have been taken so far.
    assign DATA_I = acc_total * 32'h9E37_79B1 + 32'h1234_5678;

    trace_host_reader #(.COUNT_W(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O), .CMD_CONTROL_I(CMD_CONTROL_I),
        .CMD_COUNT_I(CMD_COUNT_I), .CMD_WAIT_TRIG_I(CMD_WAIT_TRIG_I),
        .CONTROL_VALID_O(CONTROL_VALID_O), .CONTROL_READY_I(CONTROL_READY_I), .CONTROL_O(CONTROL_O),
        .STATUS_VALID_I(STATUS_VALID_I), .STATUS_READY_O(STATUS_READY_O), .STATUS_I(STATUS_I),
        .DATA_VALID_I(DATA_VALID_I), .DATA_READY_O(DATA_READY_O), .DATA_I(DATA_I),
        .OUT_VALID_O(OUT_VALID_O), .OUT_READY_I(OUT_READY_I), .OUT_DATA_O(OUT_DATA_O),
        .ABORT_I(ABORT_I), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .LAST_STATUS_O(LAST_STATUS_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Job-level reference model, compared against the DUT on every falling edge.
    initial begin : monitor
        bit m_job, m_ctrl, m_wait, m_read, m_drain, m_done, m_flag, m_ov;
        int unsigned m_rem;
        logic [31:0] m_od;
        logic [15:0] m_cw;
        logic [7:0]  m_ls;
        bit s_rst, s_abort, s_cmdv, s_wait, s_crdy, s_sv, s_dv, s_ordy;
        logic [7:0]  s_st;
        logic [15:0] s_cmd, s_cnt;
        logic [31:0] s_data;
        bit e_cv, e_dr, ov_before, load, pop;
        m_job = 0; m_ctrl = 0; m_wait = 0; m_read = 0; m_drain = 0; m_done = 0; m_flag = 0; m_ov = 0;
        m_rem = 0; m_od = 32'h0; m_cw = 16'h0; m_ls = 8'h0;
        forever begin
            @(negedge CLK_I);
            cyc++;
            s_rst = RST_I; s_abort = ABORT_I; s_cmdv = CMD_VALID_I; s_wait = CMD_WAIT_TRIG_I;
            s_crdy = CONTROL_READY_I; s_sv = STATUS_VALID_I; s_dv = DATA_VALID_I; s_ordy = OUT_READY_I;
            s_st = STATUS_I; s_cmd = CMD_CONTROL_I; s_cnt = CMD_COUNT_I; s_data = DATA_I;
            e_cv = !s_rst && m_ctrl && !s_abort;
            e_dr = !s_rst && m_read && !s_abort && (!m_ov || s_ordy);
            if (s_rst) begin
                chk("rst_cmd_ready", CMD_READY_O, 0);  chk("rst_ctrl_valid", CONTROL_VALID_O, 0);
                chk("rst_status_ready", STATUS_READY_O, 0); chk("rst_data_ready", DATA_READY_O, 0);
                chk("rst_out_valid", OUT_VALID_O, 0);  chk("rst_busy", BUSY_O, 0);
                chk("rst_done", DONE_O, 0);            chk("rst_control", CONTROL_O, 0);
                chk("rst_out_data", OUT_DATA_O, 0);    chk("rst_last_status", LAST_STATUS_O, 0);
            end else begin
                chk("cmd_ready", CMD_READY_O, 32'(!m_job));
                chk("ctrl_valid", CONTROL_VALID_O, 32'(e_cv));
                chk("status_ready", STATUS_READY_O, 1);
                chk("data_ready", DATA_READY_O, 32'(e_dr));
                chk("out_valid", OUT_VALID_O, 32'(m_ov));
                chk("busy", BUSY_O, 32'(m_job));
                chk("done", DONE_O, 32'(m_done));
                chk("last_status", LAST_STATUS_O, 32'(m_ls));
                if (e_cv) chk("control_word", CONTROL_O, 32'(m_cw));
                if (m_ov) chk("out_data", OUT_DATA_O, m_od);
                if (m_ov && s_ordy) out_q.push_back(cyc);
                if (m_done) done_q.push_back(cyc);
                if (e_cv && s_crdy) ctrl_q.push_back(cyc);
                if (e_dr && s_dv) dacc_q.push_back(cyc);
            end
            @(posedge CLK_I);
            #1;
            if (s_rst) begin
                m_job = 0; m_ctrl = 0; m_wait = 0; m_read = 0; m_drain = 0; m_done = 0; m_ov = 0;
                m_rem = 0; m_od = 32'h0; m_cw = 16'h0; m_ls = 8'h0;
            end else begin
                if (s_sv) m_ls = s_st;
                if (m_job && s_abort) begin
                    m_job = 0; m_ctrl = 0; m_wait = 0; m_read = 0; m_drain = 0; m_done = 0; m_ov = 0;
                end else begin
                    ov_before = m_ov;
                    load = e_dr && s_dv;
                    pop  = m_ov && s_ordy;
                    if (load) begin
                        m_ov = 1; m_od = s_data; m_rem--; acc_total++;
                    end else if (pop) m_ov = 0;
                    if (m_done) begin
                        m_done = 0; m_job = 0;
                    end else if (!m_job) begin
                        if (s_cmdv) begin
                            m_job = 1; m_ctrl = 1; m_cw = s_cmd; m_rem = s_cnt; m_flag = s_wait;
                        end
                    end else if (m_ctrl) begin
                        if (s_crdy) begin
                            m_ctrl = 0;
                            if (m_flag) m_wait = 1;
                            else if (m_rem > 0) m_read = 1;
                            else m_done = 1;
                        end
                    end else if (m_wait) begin
                        if (s_sv && s_st[STATUS_TRG_BIT]) begin
                            m_wait = 0;
                            if (m_rem > 0) m_read = 1; else m_done = 1;
                        end
                    end else if (m_read) begin
                        if (load && m_rem == 0) begin m_read = 0; m_drain = 1; end
                    end else if (m_drain) begin
                        if (!ov_before) begin m_drain = 0; m_done = 1; end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
        if (rnd) begin
            DATA_VALID_I    = ($urandom_range(0, 3) != 0);
            OUT_READY_I     = ($urandom_range(0, 2) != 0);
            CONTROL_READY_I = ($urandom_range(0, 1) != 0);
            STATUS_VALID_I  = ($urandom_range(0, 2) == 0);
            STATUS_I        = 8'($urandom);
            ABORT_I         = ($urandom_range(0, 59) == 0);
        end
    endtask

    task automatic send_cmd(input logic [15:0] cw, input logic [15:0] cnt, input bit wt);
        int n = 0;
        CMD_CONTROL_I = cw; CMD_COUNT_I = cnt; CMD_WAIT_TRIG_I = wt; CMD_VALID_I = 1'b1;
        while (!CMD_READY_O && n < 50) begin step(); n++; end
        chk("cmd_accept_timeout", CMD_READY_O, 1);
        step();
        CMD_VALID_I = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int n = 0;
        while (BUSY_O && n < budget) begin
            if (toggle) OUT_READY_I = !OUT_READY_I;
            step();
            n++;
        end
        chk("idle_timeout", BUSY_O, 0);
    endtask

    task automatic defaults();
        DATA_VALID_I = 1'b1; OUT_READY_I = 1'b1; CONTROL_READY_I = 1'b1;
        STATUS_VALID_I = 1'b0; STATUS_I = 8'h00; ABORT_I = 1'b0;
    endtask

    initial begin : stim
        int o0, d0, c0, a0, n;
        defaults();
        repeat (3) step();
        RST_I = 1'b0;
        #1;
        chk("post_rst_cmd_ready", CMD_READY_O, 1);
        chk("post_rst_busy", BUSY_O, 0);

        // count=4, no trigger, everything ready
        o0 = out_q.size(); d0 = done_q.size(); c0 = ctrl_q.size();
        send_cmd(16'hA123, 16'd4, 1'b0);
        wait_idle(60, 1'b0);
        chk("c4_beats", out_q.size() - o0, 4);
        chk("c4_consecutive", out_q[out_q.size()-1] - out_q[o0], 3);
        chk("c4_done_gap", done_q[done_q.size()-1] - out_q[out_q.size()-1], 2);
        chk("c4_ctrl_beats", ctrl_q.size() - c0, 1);
        chk("c4_done_pulses", done_q.size() - d0, 1);

        // count=0: DONE straight after the control beat
        o0 = out_q.size();
        send_cmd(16'h5001, 16'd0, 1'b0);
        wait_idle(20, 1'b0);
        chk("c0_done_gap", done_q[done_q.size()-1] - ctrl_q[ctrl_q.size()-1], 1);
        chk("c0_beats", out_q.size() - o0, 0);

        // wait for trigger: three non-trigger statuses, then a trigger
        o0 = out_q.size();
        send_cmd(16'h7777, 16'd2, 1'b1);
        step();
        STATUS_VALID_I = 1'b1; STATUS_I = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("trig_no_read", DATA_READY_O, 0);
            chk("trig_busy", BUSY_O, 1);
        end
        STATUS_I = 8'h81;
        step();
        STATUS_VALID_I = 1'b0;
        chk("trig_last_status", LAST_STATUS_O, 8'h81);
        chk("trig_read", DATA_READY_O, 1);
        wait_idle(40, 1'b0);
        chk("trig_beats", out_q.size() - o0, 2);

        // count=3 with the sink toggling
        o0 = out_q.size();
        OUT_READY_I = 1'b0;
        send_cmd(16'h0303, 16'd3, 1'b0);
        wait_idle(60, 1'b1);
        chk("toggle_beats", out_q.size() - o0, 3);
        defaults();

        // abort after two of eight words
        d0 = done_q.size(); a0 = dacc_q.size(); n = 0;
        send_cmd(16'h0808, 16'd8, 1'b0);
        while (dacc_q.size() - a0 < 2 && n < 40) begin step(); n++; end
        chk("abort_two_taken", dacc_q.size() - a0, 2);
        ABORT_I = 1'b1;
        #1;
        chk("abort_data_ready", DATA_READY_O, 0);
        step();
        ABORT_I = 1'b0;
        chk("abort_busy", BUSY_O, 0);
        chk("abort_out_valid", OUT_VALID_O, 0);
        chk("abort_cmd_ready", CMD_READY_O, 1);
        chk("abort_no_done", done_q.size() - d0, 0);
        send_cmd(16'h0101, 16'd1, 1'b0);
        wait_idle(30, 1'b0);
        chk("abort_next_job_done", done_q.size() - d0, 1);

        // reset while waiting for a trigger
        d0 = done_q.size();
        send_cmd(16'h0F0F, 16'd3, 1'b1);
        step();
        chk("wt_busy", BUSY_O, 1);
        RST_I = 1'b1;
        step();
        chk("wt_rst_busy", BUSY_O, 0);
        chk("wt_rst_cmd_ready", CMD_READY_O, 0);
        step();
        RST_I = 1'b0;
        #1;
        chk("wt_post_cmd_ready", CMD_READY_O, 1);
        chk("wt_no_done", done_q.size() - d0, 0);

        // randomized jobs
        rnd = 1'b1;
        for (int j = 0; j < 40; j++) begin
            send_cmd(16'($urandom), 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            wait_idle(400, 1'b0);
        end
        rnd = 1'b0;
        defaults();
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
